program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder for the computador program memory.
- Receives a byte-serial program image over a valid/ready handshake and assembles each pair of bytes into one 16-bit instruction word, high byte first.
- Drives the memory write port (mem_wr, iin, endereco_ext) with one write cycle per word at consecutive addresses from 0.
- Raises run when loading finishes, so the processor only executes a complete image.

Parameters:
- MAX_WORDS, 256: capacity in words. Loading stops once this many words are written.
- ADDR_W, 16: width of endereco_ext and words_loaded.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new load, or aborts and restarts a load in progress.
- byte_in  in  8  program byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  qualifies the final byte of the image; sampled only on low-byte acceptance.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_wr  out  1  memory write enable.
- iin  out  16  instruction word to write.
- endereco_ext  out  ADDR_W  memory write address.
- run  out  1  image complete; processor may execute.
- busy  out  1  load in progress.
- truncated  out  1  capacity reached before byte_last.
- words_loaded  out  ADDR_W  number of words written.
- checksum  out  16  modulo-2^16 sum of the written words.

Behaviour:
- Reset (async, resetn=0):
  - All outputs go to 0: mem_wr, iin, endereco_ext, run, busy, truncated, words_loaded, checksum, byte_ready.
  - State goes to IDLE.
  - Reset mid-load discards everything; no partial write completes.
- States: IDLE, HI, LO, WRITE, DONE.
  - byte_ready = 1 only in HI and LO.
  - busy = 1 in HI, LO and WRITE.
- Byte acceptance: a byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
- IDLE:
  - Waits for start.
  - On start: clear endereco_ext, words_loaded, checksum, truncated and run; go to HI.
- HI:
  - On acceptance: latch byte_in as the high byte; go to LO.
  - byte_last is ignored here.
- LO:
  - On acceptance: iin <= {hi_byte, byte_in}; latch byte_last into last_flag; mem_wr <= 1; go to WRITE.
- WRITE (exactly one cycle):
  - mem_wr=1; iin and endereco_ext are stable for the whole cycle.
  - At the closing edge: mem_wr <= 0; endereco_ext and words_loaded increment; checksum <= checksum + iin.
  - Next state:
    - last_flag=1 -> DONE.
    - Otherwise, words_loaded+1 == MAX_WORDS -> DONE with truncated <= 1.
    - Otherwise -> HI.
- DONE:
  - run=1, held until the next start or reset.
  - endereco_ext and words_loaded equal the word count N; iin holds the last word.
- start priority:
  - start is honoured in every state and has priority over a byte accepted on the same edge.
  - start in WRITE suppresses that write's counter and checksum update and clears mem_wr.
- Throughput and latency:
  - Minimum 3 cycles per word.
  - mem_wr rises on the edge that accepts the low byte.
  - run rises on the edge that closes the final WRITE cycle.
- Idle cycles: byte_valid=0 in HI or LO stalls with no side effects. Bytes presented in IDLE, WRITE or DONE are not accepted.
- Arithmetic:
  - Address and counter increment modulo 2^ADDR_W; with MAX_WORDS ≤ 2^ADDR_W, wrap cannot occur.
  - checksum wraps modulo 2^16.
- Byte order: high byte first, e.g. bytes A0,00 -> word 16'hA000.

Test Plan:
- 3-word image: start; bytes A0,00, A4,01, 60,00 with byte_last on the final byte -> three single-cycle mem_wr pulses at addresses 0,1,2 with iin A000, A401, 6000; then run=1, words_loaded=3, checksum=16'hA401, truncated=0.
- Backpressure gaps: same image with byte_valid low for 2 cycles between every byte -> identical writes and final values; mem_wr never high outside WRITE.
- Capacity: MAX_WORDS=4; stream 6 words with no byte_last -> exactly 4 writes at addresses 0..3; truncated=1, run=1, byte_ready=0 afterwards.
- Abort: start issued after byte A0 of the second word -> counters and checksum clear; reload of image 6000 (last) -> a single write at address 0, words_loaded=1, checksum=16'h6000.
- Async reset: resetn low during WRITE -> mem_wr drops to 0 immediately and all outputs are 0; after release the block stays in IDLE, bytes are not accepted and run=0.
- byte_last on a high byte: bytes C3(last),04 -> byte_last ignored on C3; 16'hC304 written; block returns to HI and remains busy.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The master drives program bytes; the slave (the loader) accepts them and drives the memory port.
interface program_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              mem_wr;
  logic [15:0]       iin;
  logic [ADDR_W-1:0] endereco_ext;

  modport master (
    output byte_in, byte_valid, byte_last,
    input  byte_ready, mem_wr, iin, endereco_ext
  );

  modport slave (
    input  byte_in, byte_valid, byte_last,
    output byte_ready, mem_wr, iin, endereco_ext
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a byte-serial program image into 16-bit words, high byte first, and writes them
// to consecutive program-memory addresses from 0. Raises run once the whole image is in memory.
module program_loader #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              run,
  output logic              busy,
  output logic              truncated,
  output logic [ADDR_W-1:0] words_loaded,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] CAPACITY = (ADDR_W + 1)'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       iin_q, iin_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [15:0]       csum_q, csum_d;
  logic              trunc_q, trunc_d;

  logic accept;
  logic full;

  assign accept = bus.byte_valid & bus.byte_ready;
  // The word being written in WRITE is the last one that fits.
  assign full   = (({1'b0, count_q} + (ADDR_W + 1)'(1)) == CAPACITY);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset,
  // so a reset mid-load removes the write strobe at once instead of at the next edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output takes a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_HI;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_HI:    if (accept) state_d = S_LO;
        S_LO:    if (accept) state_d = S_WRITE;
        S_WRITE: state_d = (last_q || full) ? S_DONE : S_HI;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready = 1'b0;
    bus.mem_wr     = 1'b0;
    busy           = 1'b0;
    run            = 1'b0;
    unique case (state_q)
      S_HI: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
      end
      S_LO: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
      end
      S_WRITE: begin
        bus.mem_wr = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  run = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: start wins over any byte accepted or write closing on the same edge.
  always_comb begin
    hi_d    = hi_q;
    iin_d   = iin_q;
    last_d  = last_q;
    count_d = count_q;
    csum_d  = csum_q;
    trunc_d = trunc_q;
    if (start) begin
      last_d  = 1'b0;
      count_d = '0;
      csum_d  = '0;
      trunc_d = 1'b0;
    end else begin
      unique case (state_q)
        S_HI: begin
          if (accept) hi_d = bus.byte_in;
        end
        S_LO: begin
          if (accept) begin
            iin_d  = {hi_q, bus.byte_in};
            last_d = bus.byte_last;
          end
        end
        S_WRITE: begin
          count_d = count_q + ADDR_W'(1);
          csum_d  = csum_q + iin_q;
          if (!last_q && full) trunc_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_q    <= '0;
      iin_q   <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      csum_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      iin_q   <= iin_d;
      last_q  <= last_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      trunc_q <= trunc_d;
    end
  end

  // Address and word count always advance together, so one counter feeds both.
  assign bus.iin          = iin_q;
  assign bus.endereco_ext = count_q;
  assign words_loaded     = count_q;
  assign checksum         = csum_q;
  assign truncated        = trunc_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized images
// compared against a word-list reference model of the loading rules.
module tb_program_loader;
  localparam int MAXW = 4;
  localparam int AW   = 16;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          run, busy, truncated;
  logic [AW-1:0] words_loaded;
  logic [15:0]   checksum;

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .bus          (bus),
    .run          (run),
    .busy         (busy),
    .truncated    (truncated),
    .words_loaded (words_loaded),
    .checksum     (checksum)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  wr_streak  = 0;
  int  max_streak = 0;

  // Write monitor: samples the memory port 2 time units after each rising edge.
  always @(posedge clock) begin
    #2;
    if (bus.mem_wr === 1'b1) begin
      wr_q.push_back('{addr: bus.endereco_ext, data: bus.iin});
      wr_streak++;
      if (wr_streak > max_streak) max_streak = wr_streak;
    end else begin
      wr_streak = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    bus.byte_in    = b;
    bus.byte_last  = last;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (bus.byte_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout byte=%h not accepted after %0d cycles", b, n);
    end
    @(negedge clock);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (run !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.byte_ready, bus.mem_wr, bus.iin, bus.endereco_ext, run, busy, truncated,
         words_loaded, checksum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b wr=%b iin=%h addr=%h run=%b busy=%b trunc=%b words=%h csum=%h expected all zero",
               bus.byte_ready, bus.mem_wr, bus.iin, bus.endereco_ext, run, busy, truncated,
               words_loaded, checksum);
    end
    resetn         = 1'b1;
    bus.byte_in    = 8'h5A;
    bus.byte_valid = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if ({bus.byte_ready, busy, run} !== 3'b000 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL idle_no_accept got ready=%b busy=%b run=%b writes=%0d expected 0 0 0 0",
               bus.byte_ready, busy, run, wr_q.size());
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_image(input int gap, input string tag);
    logic [15:0] exp_data[3] = '{16'hA000, 16'hA401, 16'h6000};
    wr_q.delete();
    max_streak = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(exp_data[i][15:8], 1'b0, gap);
      send_byte(exp_data[i][7:0], i == 2, gap);
    end
    wait_run();
    checks++;
    if (wr_q.size() != 3) begin
      failures++;
      $display("FAIL %s_write_count got=%0d expected=3", tag, wr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_q[i].addr !== 16'(i) || wr_q[i].data !== exp_data[i]) begin
          failures++;
          $display("FAIL %s_write%0d got addr=%h data=%h expected addr=%h data=%h",
                   tag, i, wr_q[i].addr, wr_q[i].data, 16'(i), exp_data[i]);
        end
      end
    end
    checks++;
    if (run !== 1'b1 || words_loaded !== 16'd3 || checksum !== 16'hA401 || truncated !== 1'b0) begin
      failures++;
      $display("FAIL %s_final got run=%b words=%0d csum=%h trunc=%b expected 1 3 a401 0",
               tag, run, words_loaded, checksum, truncated);
    end
    checks++;
    if (bus.endereco_ext !== 16'd3 || bus.iin !== 16'h6000 || busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_state got addr=%h iin=%h busy=%b ready=%b expected 0003 6000 0 0",
               tag, bus.endereco_ext, bus.iin, busy, bus.byte_ready);
    end
    checks++;
    if (max_streak != 1) begin
      failures++;
      $display("FAIL %s_wr_pulse_width got=%0d expected=1", tag, max_streak);
    end
  endtask

  task automatic test_capacity();
    logic [15:0] words[6] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'h7777};
    logic [15:0] exp_sum = 16'h0;
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < MAXW; i++) begin
      send_byte(words[i][15:8], 1'b0, 0);
      send_byte(words[i][7:0], 1'b0, 0);
      exp_sum = exp_sum + words[i];
    end
    wait_run();
    // Remaining bytes of the 6-word stream are offered but must be refused.
    bus.byte_in    = words[MAXW][15:8];
    bus.byte_valid = 1'b1;
    repeat (6) @(negedge clock);
    bus.byte_valid = 1'b0;
    checks++;
    if (wr_q.size() != MAXW) begin
      failures++;
      $display("FAIL cap_write_count got=%0d expected=%0d", wr_q.size(), MAXW);
    end else begin
      for (int i = 0; i < MAXW; i++) begin
        checks++;
        if (wr_q[i].addr !== 16'(i) || wr_q[i].data !== words[i]) begin
          failures++;
          $display("FAIL cap_write%0d got addr=%h data=%h expected addr=%h data=%h",
                   i, wr_q[i].addr, wr_q[i].data, 16'(i), words[i]);
        end
      end
    end
    checks++;
    if (truncated !== 1'b1 || run !== 1'b1 || bus.byte_ready !== 1'b0 ||
        words_loaded !== 16'(MAXW) || checksum !== exp_sum) begin
      failures++;
      $display("FAIL cap_final got trunc=%b run=%b ready=%b words=%0d csum=%h expected 1 1 0 %0d %h",
               truncated, run, bus.byte_ready, words_loaded, checksum, MAXW, exp_sum);
    end
  endtask

  task automatic test_abort();
    pulse_start();
    send_byte(8'hA0, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'hA0, 1'b0, 0);
    pulse_start();
    checks++;
    if (words_loaded !== 16'd0 || checksum !== 16'd0 || busy !== 1'b1 || run !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear got words=%0d csum=%h busy=%b run=%b expected 0 0000 1 0",
               words_loaded, checksum, busy, run);
    end
    wr_q.delete();
    send_byte(8'h60, 1'b0, 0);
    send_byte(8'h00, 1'b1, 0);
    wait_run();
    checks++;
    if (wr_q.size() != 1 || wr_q[0].addr !== 16'd0 || wr_q[0].data !== 16'h6000 ||
        words_loaded !== 16'd1 || checksum !== 16'h6000) begin
      failures++;
      $display("FAIL abort_reload got writes=%0d words=%0d csum=%h expected 1 write 0:6000 words=1 csum=6000",
               wr_q.size(), words_loaded, checksum);
    end
  endtask

  task automatic test_start_in_write();
    pulse_start();
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b1, 0);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.iin !== 16'h1234) begin
      failures++;
      $display("FAIL wr_latency got mem_wr=%b iin=%h expected 1 1234", bus.mem_wr, bus.iin);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (bus.mem_wr !== 1'b0 || words_loaded !== 16'd0 || checksum !== 16'd0 ||
        busy !== 1'b1 || bus.byte_ready !== 1'b1 || run !== 1'b0) begin
      failures++;
      $display("FAIL start_in_write got wr=%b words=%0d csum=%h busy=%b ready=%b run=%b expected 0 0 0000 1 1 0",
               bus.mem_wr, words_loaded, checksum, busy, bus.byte_ready, run);
    end
    wr_q.delete();
    send_byte(8'h60, 1'b0, 0);
    send_byte(8'h00, 1'b1, 0);
    wait_run();
    checks++;
    if (wr_q.size() != 1 || words_loaded !== 16'd1 || checksum !== 16'h6000) begin
      failures++;
      $display("FAIL start_in_write_reload got writes=%0d words=%0d csum=%h expected 1 1 6000",
               wr_q.size(), words_loaded, checksum);
    end
  endtask

  task automatic test_reset_in_write();
    pulse_start();
    send_byte(8'hAB, 1'b0, 0);
    send_byte(8'hCD, 1'b0, 0);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.byte_ready, bus.mem_wr, bus.iin, bus.endereco_ext, run, busy, truncated,
         words_loaded, checksum} !== '0) begin
      failures++;
      $display("FAIL reset_in_write got wr=%b iin=%h addr=%h run=%b busy=%b words=%h csum=%h expected all zero",
               bus.mem_wr, bus.iin, bus.endereco_ext, run, busy, words_loaded, checksum);
    end
    @(negedge clock) resetn = 1'b1;
    wr_q.delete();
    bus.byte_in    = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (4) @(negedge clock);
    bus.byte_valid = 1'b0;
    checks++;
    if (bus.byte_ready !== 1'b0 || busy !== 1'b0 || run !== 1'b0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_idle got ready=%b busy=%b run=%b writes=%0d expected 0 0 0 0",
               bus.byte_ready, busy, run, wr_q.size());
    end
  endtask

  task automatic test_last_on_high();
    wr_q.delete();
    pulse_start();
    send_byte(8'hC3, 1'b1, 0);
    send_byte(8'h04, 1'b0, 0);
    @(negedge clock);
    checks++;
    if (wr_q.size() != 1 || wr_q[0].data !== 16'hC304 || wr_q[0].addr !== 16'd0) begin
      failures++;
      $display("FAIL last_on_high_write got writes=%0d expected one write 0:c304", wr_q.size());
    end
    checks++;
    if (busy !== 1'b1 || bus.byte_ready !== 1'b1 || run !== 1'b0 || words_loaded !== 16'd1) begin
      failures++;
      $display("FAIL last_on_high_state got busy=%b ready=%b run=%b words=%0d expected 1 1 0 1",
               busy, bus.byte_ready, run, words_loaded);
    end
  endtask

  // Reference model: an image of nw words, optionally flagged last on its final word, loads
  // min(nw, MAXW) words; it is truncated unless the flagged word fits within capacity.
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int          nw        = int'($urandom_range(1, 6));
      bit          with_last = (nw < MAXW) ? 1'b1 : 1'($urandom_range(0, 1));
      int          n_exp     = (nw < MAXW) ? nw : MAXW;
      bit          exp_trunc = !(with_last && nw <= MAXW);
      logic [15:0] words[$];
      logic [15:0] exp_sum   = 16'h0;
      for (int i = 0; i < nw; i++) words.push_back(16'($urandom));
      for (int i = 0; i < n_exp; i++) exp_sum = exp_sum + words[i];
      wr_q.delete();
      pulse_start();
      for (int i = 0; i < n_exp; i++) begin
        send_byte(words[i][15:8], 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        send_byte(words[i][7:0], with_last && (i == nw - 1), int'($urandom_range(0, 2)));
      end
      wait_run();
      checks++;
      if (wr_q.size() != n_exp) begin
        failures++;
        $display("FAIL rand%0d_write_count got=%0d expected=%0d", it, wr_q.size(), n_exp);
      end else begin
        for (int i = 0; i < n_exp; i++) begin
          checks++;
          if (wr_q[i].addr !== 16'(i) || wr_q[i].data !== words[i]) begin
            failures++;
            $display("FAIL rand%0d_write%0d got addr=%h data=%h expected addr=%h data=%h",
                     it, i, wr_q[i].addr, wr_q[i].data, 16'(i), words[i]);
          end
        end
      end
      checks++;
      if (run !== 1'b1 || truncated !== exp_trunc || words_loaded !== 16'(n_exp) ||
          checksum !== exp_sum || busy !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_final got run=%b trunc=%b words=%0d csum=%h busy=%b expected 1 %b %0d %h 0",
                 it, run, truncated, words_loaded, checksum, busy, exp_trunc, n_exp, exp_sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_image(0, "image");
    test_image(2, "gaps");
    test_capacity();
    test_abort();
    test_start_in_write();
    test_reset_in_write();
    test_last_on_high();
    test_random(25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
